// File: rtl/mm2s_frame_checker.sv
// Frame/line framing checker for an MM2S video stream: validates tuser (SOF) and
// tlast (EOL) placement, counts good frames and reports each good frame's data sum.
module mm2s_frame_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 48
) (
    input  logic                  m_axis_mm2s_aclk,
    input  logic                  m_axis_mm2s_aresetn,
    input  logic                  enable,
    input  logic [7:0]            stall_pattern,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic [15:0]           xCord,
    output logic [15:0]           yCord,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic [31:0]           checksum,
    output logic [3:0]            err_flags
);
    typedef enum logic [1:0] {IDLE, ACTIVE, RESYNC} state_t;

    localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

    state_t      state_q;
    logic [2:0]  phase_q;
    logic [15:0] x_q, y_q, frame_count_q;
    logic [31:0] acc_q, checksum_q;
    logic [3:0]  err_q;
    logic        frame_done_q;

    logic        accept, in_frame, take_beat, at_eol;
    logic        e_early, e_late, e_user, beat_err;
    logic [15:0] beat_x, beat_y;
    logic [31:0] acc_d;

    assign s_axis_tready = m_axis_mm2s_aresetn & enable & ~stall_pattern[phase_q];
    assign accept        = s_axis_tvalid & s_axis_tready;

    // A SOF beat arriving outside a frame is judged as the beat at (0,0) on an empty sum.
    always_comb begin
        in_frame  = (state_q == ACTIVE);
        take_beat = in_frame | s_axis_tuser;
        beat_x    = in_frame ? x_q : 16'd0;
        beat_y    = in_frame ? y_q : 16'd0;
        acc_d     = (in_frame ? acc_q : 32'd0) + 32'(s_axis_tdata);
        at_eol    = (beat_x == X_LAST);
        e_early   = s_axis_tlast & ~at_eol;
        e_late    = ~s_axis_tlast & at_eol;
        e_user    = in_frame & s_axis_tuser;
        beat_err  = e_early | e_late | e_user;
    end

    always_ff @(posedge m_axis_mm2s_aclk or negedge m_axis_mm2s_aresetn) begin
        if (!m_axis_mm2s_aresetn) begin
            state_q       <= IDLE;
            phase_q       <= 3'd0;
            x_q           <= 16'd0;
            y_q           <= 16'd0;
            acc_q         <= 32'd0;
            checksum_q    <= 32'd0;
            frame_count_q <= 16'd0;
            frame_done_q  <= 1'b0;
            err_q         <= 4'd0;
        end else begin
            phase_q      <= phase_q + 3'd1;
            frame_done_q <= 1'b0;
            if (accept) begin
                if (state_q == IDLE && !s_axis_tuser) begin
                    err_q[0] <= 1'b1;
                end else if (take_beat) begin
                    if (beat_err) begin
                        err_q   <= err_q | {e_user, e_late, e_early, 1'b0};
                        state_q <= RESYNC;
                        x_q     <= 16'd0;
                        y_q     <= 16'd0;
                    end else if (at_eol && beat_y == Y_LAST) begin
                        checksum_q    <= acc_d;
                        frame_count_q <= frame_count_q + 16'd1;
                        frame_done_q  <= 1'b1;
                        acc_q         <= acc_d;
                        state_q       <= IDLE;
                        x_q           <= 16'd0;
                        y_q           <= 16'd0;
                    end else if (at_eol) begin
                        acc_q   <= acc_d;
                        state_q <= ACTIVE;
                        x_q     <= 16'd0;
                        y_q     <= beat_y + 16'd1;
                    end else begin
                        acc_q   <= acc_d;
                        state_q <= ACTIVE;
                        x_q     <= beat_x + 16'd1;
                        y_q     <= beat_y;
                    end
                end
            end
        end
    end

    assign xCord       = x_q;
    assign yCord       = y_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign checksum    = checksum_q;
    assign err_flags   = err_q;
endmodule

// File: doc/mm2s_frame_checker.md
MM2S_FRAME_CHECKER -- requirements
Module: mm2s_frame_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning mm2s stream tdata width.
REQ-002 SHALL have parameter IMG_WIDTH, default 64, meaning pixels (beats) per line.
REQ-003 SHALL have parameter IMG_HEIGHT, default 48, meaning lines per frame.
REQ-004 SHALL have port m_axis_mm2s_aclk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port m_axis_mm2s_aresetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1  1 = accept stream; 0 = tready low, state held.
REQ-007 SHALL have port stall_pattern  in  8  backpressure mask; bit set = tready low in that phase.
REQ-008 SHALL have port s_axis_tvalid  in  1  upstream beat valid.
REQ-009 SHALL have port s_axis_tready  out  1  beat accepted when tvalid & tready.
REQ-010 SHALL have port s_axis_tuser  in  1  start-of-frame flag on first beat.
REQ-011 SHALL have port s_axis_tlast  in  1  end-of-line flag on last beat of a line.
REQ-012 SHALL have port s_axis_tdata  in  DATA_WIDTH  pixel data.
REQ-013 SHALL have port xCord / yCord  out  16 each  position of the next expected beat.
REQ-014 SHALL have port frame_done  out  1  one-cycle pulse when a frame completes without error.
REQ-015 SHALL have port frame_count  out  16  count of good frames.
REQ-016 SHALL have port checksum  out  32  sum of last good frame's tdata.
REQ-017 SHALL have port err_flags  out  4  sticky: [0] no-SOF, [1] early tlast, [2] late/missing tlast, [3] stray tuser mid-frame.

Function
REQ-018 SHALL define "accept" as s_axis_tvalid & s_axis_tready at a rising clock edge; only accepted beats change state.
REQ-019 SHALL drive s_axis_tready = enable & ~stall_pattern[phase], phase = 3-bit free-running counter, incrementing every cycle, wrapping 7->0.
REQ-020 SHALL implement states IDLE, ACTIVE, RESYNC.
REQ-021 IDLE: accepted beat with tuser=1 -> ACTIVE, x=1, y=0, accumulator=tdata; tuser=0 -> set err[0], stay IDLE, beat dropped.
REQ-022 ACTIVE: each accepted beat adds zero-extended tdata into 32-bit accumulator, modulo 2^32.
REQ-023 ACTIVE: tlast=1 with x != IMG_WIDTH-1 -> set err[1], go RESYNC.
REQ-024 ACTIVE: tlast=0 with x == IMG_WIDTH-1 -> set err[2], go RESYNC.
REQ-025 ACTIVE: tuser=1 on any beat -> set err[3], go RESYNC; no restart on that beat.
REQ-026 ACTIVE: tlast=1 at x == IMG_WIDTH-1 and y < IMG_HEIGHT-1 -> x=0, y+1.
REQ-027 ACTIVE: tlast=1 at x == IMG_WIDTH-1 and y == IMG_HEIGHT-1 -> checksum <= accumulator incl. this beat, frame_count+1 (wraps FFFF->0), frame_done=1 next cycle only, x=y=0, go IDLE.
REQ-028 RESYNC: discard beats with tuser=0; tuser=1 beat handled as in IDLE and goes ACTIVE.
REQ-029 Simultaneous error conditions on one beat SHALL set all applicable err bits; the next state is RESYNC.
REQ-030 err_flags SHALL be sticky; cleared only by reset.
REQ-031 checksum and frame_count SHALL update only on good frames; errored frames leave them unchanged.
REQ-032 enable=0 mid-frame SHALL freeze x, y, state and accumulator; phase counter keeps running.
REQ-033 IMG_WIDTH=1 SHALL treat every beat as requiring tlast=1.

Reset
REQ-034 While m_axis_mm2s_aresetn=0: state IDLE, s_axis_tready=0, x=y=0, phase=0, accumulator=0, checksum=0, frame_count=0, frame_done=0, err_flags=0.
REQ-035 Reset assertion mid-frame SHALL abort immediately; after release the block waits in IDLE for a new tuser.
REQ-036 First tready assertion SHALL occur in the first cycle after release in which enable=1 and the stall mask bit is 0.

Verification
REQ-037 IMG_WIDTH=4, IMG_HEIGHT=2, stall=00, tdata=1..8 with correct tuser/tlast -> frame_done pulse, checksum=36, frame_count=1, err=0.
REQ-038 Same frame, stall=0xAA -> tready toggles every cycle, same checksum=36, frame completes in 16 cycles.
REQ-039 tlast on 3rd beat of line 0 -> err=0010, frame dropped; next clean frame (tdata all 2) -> checksum=16, frame_count=1.
REQ-040 Stream beginning with tuser=0 beats, then a valid frame -> err[0]=1, valid frame is counted.
REQ-041 tuser asserted on beat 5 -> err[3]=1, RESYNC; a following valid frame completes with frame_done.
REQ-042 Reset pulsed after 3 beats of a frame -> all outputs 0; a fresh frame afterwards completes with frame_count=1.
